// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite plot arbiter.
//   SCREEN_W/SCREEN_H : VGA adapter raster (160x120)
//   SPR_DIM/SPR_PIX   : sprite is SPR_DIM x SPR_DIM, SPR_PIX pixels, row-major
//   state_t           : arbiter FSM states
//   pix_idx_t         : index of the pixel within a sprite scan
//   sprite_t          : one latched sprite request (anchor, colour, mask)
package sprite_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPR_DIM  = 3;
  localparam int SPR_PIX  = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ERASE,
    DRAW,
    DONE
  } state_t;

  typedef logic [3:0] pix_idx_t;

  localparam pix_idx_t LAST_PIX = pix_idx_t'(SPR_PIX - 1);

  typedef struct packed {
    logic [7:0]         x;
    logic [6:0]         y;
    logic [2:0]         colour;
    logic [SPR_PIX-1:0] mask;
  } sprite_t;

  // Column / row of pixel k in a row-major scan.
  function automatic logic [1:0] pix_col(pix_idx_t k);
    return 2'(k % pix_idx_t'(SPR_DIM));
  endfunction

  function automatic logic [1:0] pix_row(pix_idx_t k);
    return 2'(k / pix_idx_t'(SPR_DIM));
  endfunction

  // Offsets are at most SPR_DIM-1, so one conditional subtract is
  // enough to wrap back onto the screen.
  function automatic logic [7:0] wrap_x(logic [7:0] a, logic [1:0] d);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, d};
    if (s >= 9'(SCREEN_W)) s = s - 9'(SCREEN_W);
    return s[7:0];
  endfunction

  function automatic logic [6:0] wrap_y(logic [6:0] a, logic [1:0] d);
    logic [7:0] s;
    s = {1'b0, a} + {6'b0, d};
    if (s >= 8'(SCREEN_H)) s = s - 8'(SCREEN_H);
    return s[6:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     : request vector
//   ptr     : highest-priority index this round (must be < NUM_REQ)
//   gnt     : one-hot winner (all zero when no request)
//   gnt_idx : binary index of the winner
//   any     : at least one request is pending
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk NUM_REQ slots starting at ptr, wrapping; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_plot_arbiter.sv
// sprite_plot_arbiter: shares the single-pixel VGA plot port among NUM_REQ
// sprite drawers. A granted 3x3 masked sprite is serialised into nine
// consecutive pixel cycles, row-major, wrapping at the screen edges.
//   CLOCK_50, resetN           : clock, async active-low reset
//   req[i]                     : level request, held until done[i]
//   req_x/req_y/req_colour/req_mask : flattened per-requester sprite data
//   grant                      : one-hot owner, LOAD through DONE
//   done                       : one-cycle pulse to the owner in DONE
//   busy                       : FSM not in IDLE
//   vga_x/vga_y/vga_colour/vga_plot : registered pixel write to the adapter
// Build option: define SPRITE_ERASE_EN to keep the last drawn sprite per
// requester and blank it (colour 0) before each redraw.
module sprite_plot_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   resetN,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_x,
  input  logic [NUM_REQ*7-1:0]   req_y,
  input  logic [NUM_REQ*3-1:0]   req_colour,
  input  logic [NUM_REQ*9-1:0]   req_mask,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        own_q, own_d;
  sprite_t              spr_q, spr_d;
  pix_idx_t             pix_q, pix_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [7:0]           vx_q, vx_d;
  logic [6:0]           vy_q, vy_d;
  logic [2:0]           vc_q, vc_d;
  logic                 plot_q, plot_d;

  // Pixel source selected by the FSM for the next cycle.
  logic                 emit_en;
  sprite_t              emit_spr;
  pix_idx_t             emit_k;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

  sprite_t              req_spr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_spr[g] = '{x:      req_x[8*g +: 8],
                          y:      req_y[7*g +: 7],
                          colour: req_colour[3*g +: 3],
                          mask:   req_mask[SPR_PIX*g +: SPR_PIX]};
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

`ifdef SPRITE_ERASE_EN
  // Last sprite drawn per requester; valid once a draw has completed.
  sprite_t            last_q [NUM_REQ];
  sprite_t            last_d [NUM_REQ];
  logic [NUM_REQ-1:0] vld_q, vld_d;

  always_comb begin
    last_d = last_q;
    vld_d  = vld_q;
    if (state_q == DONE) begin
      last_d[own_q] = spr_q;
      vld_d[own_q]  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      last_q <= '{default: '0};
      vld_q  <= '0;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
    end
  end
`endif

  // Outputs are registered from next-state values, so pixel k of a scan
  // is on the port during the cycle the FSM holds pix_q == k.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    spr_d    = spr_q;
    pix_d    = pix_q;
    grant_d  = grant_q;
    done_d   = '0;
    vx_d     = vx_q;
    vy_d     = vy_q;
    vc_d     = vc_q;
    plot_d   = 1'b0;
    emit_en  = 1'b0;
    emit_spr = spr_q;
    emit_k   = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = LOAD;
          own_d   = arb_idx;
          spr_d   = req_spr[arb_idx];
          grant_d = arb_gnt;
        end
      end

      LOAD: begin
        pix_d   = '0;
        state_d = DRAW;
        emit_en = 1'b1;
`ifdef SPRITE_ERASE_EN
        if (vld_q[own_q]) begin
          state_d         = ERASE;
          emit_spr        = last_q[own_q];
          emit_spr.colour = '0;
        end
`endif
      end

      ERASE: begin
`ifdef SPRITE_ERASE_EN
        emit_en = 1'b1;
        if (pix_q == LAST_PIX) begin
          state_d = DRAW;
          pix_d   = '0;
        end else begin
          pix_d           = pix_q + pix_idx_t'(1);
          emit_spr        = last_q[own_q];
          emit_spr.colour = '0;
          emit_k          = pix_d;
        end
`else
        state_d = IDLE;
`endif
      end

      DRAW: begin
        if (pix_q == LAST_PIX) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          pix_d   = pix_q + pix_idx_t'(1);
          emit_en = 1'b1;
          emit_k  = pix_d;
        end
      end

      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + IW'(1);
      end

      default: state_d = IDLE;
    endcase

    if (emit_en) begin
      vx_d   = wrap_x(emit_spr.x, pix_col(emit_k));
      vy_d   = wrap_y(emit_spr.y, pix_row(emit_k));
      vc_d   = emit_spr.colour;
      plot_d = emit_spr.mask[emit_k];
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      spr_q   <= '0;
      pix_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      spr_q   <= spr_d;
      pix_q   <= pix_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// tb_sprite_plot_arbiter: table-driven single transactions plus hand-written
// round-robin and mid-transaction reset sequences. Expected pixels are
// pushed to a scoreboard when stimulus is driven and popped on vga_plot.
// Build option SPRITE_ERASE_EN must match the RTL build.
module tb_sprite_plot_arbiter;

  localparam int N = 4;

`ifdef SPRITE_ERASE_EN
  localparam bit ERASE_ON = 1'b1;
`else
  localparam bit ERASE_ON = 1'b0;
`endif

  logic           CLOCK_50 = 1'b0;
  logic           resetN   = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [N*8-1:0] req_x    = '0;
  logic [N*7-1:0] req_y    = '0;
  logic [N*3-1:0] req_colour = '0;
  logic [N*9-1:0] req_mask = '0;
  logic [N-1:0]   grant, done;
  logic           busy;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  sprite_plot_arbiter #(.NUM_REQ(N)) dut (
    .CLOCK_50   (CLOCK_50),
    .resetN     (resetN),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_mask   (req_mask),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct { int r; int x; int y; int c; int m; } vec_t;
  typedef struct { int x; int y; int c; } pix_t;

  pix_t exp_q[$];
  int   lat_q[$];
  int   total = 0;
  int   bad   = 0;
  int   lx[N], ly[N], lm[N];
  bit   lv[N];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_pixels(input int x, input int y, input int c, input int m);
    for (int k = 0; k < 9; k++)
      if (m[k]) exp_q.push_back('{(x + k % 3) % 160, (y + k / 3) % 120, c});
  endtask

  // Model: erase pass (colour 0 at the stored sprite) precedes the draw
  // once the requester has a completed draw. done lands in the 11th cycle
  // of grant (20th with erase), i.e. 10 or 19 edges after grant rises.
  task automatic push_sprite(input vec_t v);
    if (ERASE_ON && lv[v.r]) begin
      push_pixels(lx[v.r], ly[v.r], 0, lm[v.r]);
      lat_q.push_back(19);
    end else begin
      lat_q.push_back(10);
    end
    push_pixels(v.x, v.y, v.c, v.m);
    lx[v.r] = v.x; ly[v.r] = v.y; lm[v.r] = v.m; lv[v.r] = 1'b1;
  endtask

  task automatic drive(input vec_t v);
    req_x[8*v.r +: 8]      = 8'(v.x);
    req_y[7*v.r +: 7]      = 7'(v.y);
    req_colour[3*v.r +: 3] = 3'(v.c);
    req_mask[9*v.r +: 9]   = 9'(v.m);
  endtask

  // Waits (bounded) for a new grant to r, then for its done pulse.
  task automatic serve(input int r, input int gap_exp);
    int n;
    int lat;
    n = 0;
    do begin @(negedge CLOCK_50); n++; end
    while (!(grant != 0 && done == 0) && n < 60);
    chk("grant_gap", n, gap_exp);
    chk("grant_owner", grant, 1 << r);
    chk("plot_in_load", vga_plot, 0);
    chk("busy_in_load", busy, 1);
    lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
    n = 0;
    do begin @(negedge CLOCK_50); n++; end
    while (done == 0 && n < 60);
    chk("done_lat", n, lat);
    chk("done_owner", done, 1 << r);
    chk("grant_in_done", grant, 1 << r);
    chk("plot_in_done", vga_plot, 0);
  endtask

  task automatic idle_checks();
    @(negedge CLOCK_50);
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    chk("idle_done", done, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic do_txn(input vec_t v);
    @(negedge CLOCK_50);
    drive(v);
    req[v.r] = 1'b1;
    push_sprite(v);
    serve(v.r, 1);
    req[v.r] = 1'b0;
    idle_checks();
  endtask

  // Scoreboard: every plotted pixel must match the head of the queue.
  always @(negedge CLOCK_50) begin : mon
    pix_t e;
    if (resetN && vga_plot) begin
      if (exp_q.size() == 0) chk("plot_spurious", vga_plot, 0);
      else begin
        e = exp_q.pop_front();
        chk("pixel", {14'b0, vga_x, vga_y, vga_colour}, e.x * 1024 + e.y * 8 + e.c);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0] = '{0,  80,  60, 7, 'h1FF};
    tbl[1] = '{1,  20,  30, 5, 'b010_111_010};
    tbl[2] = '{1,  10,  10, 2, 'h1FF};
    tbl[3] = '{1,  12,  10, 6, 'h1FF};
    tbl[4] = '{2,   0,   0, 1, 'h155};
    tbl[5] = '{3, 159, 119, 3, 'h1FF};
    for (int i = 0; i < N; i++) lv[i] = 1'b0;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("rst_plot", vga_plot, 0);
    resetN = 1'b1;
    @(negedge CLOCK_50);
    chk("idle_after_rst", busy, 0);

    // Single transactions, ending on requester 3 so ptr returns to 0
    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // Round-robin with all requesters held: order 0,1,2,3,0
    @(negedge CLOCK_50);
    for (int i = 0; i < N; i++) begin
      v = '{i, 30 + 10 * i, 40 + 5 * i, i + 1, 'h1FF};
      drive(v);
    end
    for (int i = 0; i < N; i++) push_sprite('{i, 30 + 10 * i, 40 + 5 * i, i + 1, 'h1FF});
    push_sprite('{0, 30, 40, 1, 'h1FF});
    req = '1;
    serve(0, 1);
    serve(1, 2);
    serve(2, 2);
    serve(3, 2);
    serve(0, 2);
    req = '0;
    idle_checks();

    // Reset during pixel 4 of requester 2 (ptr is 1 here)
    @(negedge CLOCK_50);
    v = '{2, 40, 50, 4, 'h1FF};
    drive(v);
    req[2] = 1'b1;
    push_sprite(v);
    @(negedge CLOCK_50);
    chk("pre_rst_grant", grant, 4);
    repeat (5) @(posedge CLOCK_50);
    #2;
    chk("pre_rst_plot", vga_plot, 1);
    resetN = 1'b0;
    #1;
    chk("midrst_plot", vga_plot, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_xyc", {vga_x, vga_y, vga_colour}, 0);
    exp_q.delete();
    lat_q.delete();
    for (int i = 0; i < N; i++) lv[i] = 1'b0;
    req = '0;
    @(negedge CLOCK_50);
    resetN = 1'b1;

    // Arbitration restarts at 0: with req 0 and 2 pending, 0 wins first
    @(negedge CLOCK_50);
    v = '{0, 100, 5, 6, 'h0F3};
    drive(v);
    push_sprite(v);
    v = '{2, 158, 118, 2, 'h1FF};
    drive(v);
    push_sprite(v);
    req = 4'b0101;
    serve(0, 1);
    serve(2, 2);
    req = '0;
    idle_checks();

    chk("sb_final", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
